debounce_scanner: RTL and testbench
===================================

# debounce_scanner

Time-shared debounce controller for the slow front-panel and key/PTT inputs. It round-robins a single stability-count datapath across CHANNELS asynchronous inputs, one channel per clock, at a prescaled sample rate. It keeps one saturating counter per channel in a register array and presents clean levels to the control logic. An optional single-entry change-event port tells the host interface which channel moved and to what level.

## Interface
- CHANNELS, 4: number of inputs scanned (2..16).
- PRESCALE, 1024: clocks per sample tick (must exceed CHANNELS+1).
- STABLE, 4: consecutive differing samples required before an output toggles (2..16).
- clock  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- in  in  CHANNELS  raw asynchronous inputs.
- out  out  CHANNELS  debounced levels.
- busy  out  1  high while a scan pass is in progress.
- event_valid  out  1  change event pending (present only with macro).
- event_chan  out  clog2(CHANNELS)  channel index of the pending event.
- event_level  out  1  new level of that channel.
- event_ack  in  1  consumer acknowledge; pops the pending event.
- event_ovf  out  1  sticky flag: an event was lost; cleared only by reset.

## Operation
- Two-flop synchronizer on all of `in`, always present. The synchronized vector is `s`.
- Prescaler `pcnt` counts 0..PRESCALE-1 and wraps. `tick` is asserted when `pcnt == PRESCALE-1`.
- FSM has two states, IDLE and SCAN.
  - IDLE -> SCAN on `tick`, loading `idx = 0`.
  - In SCAN, one channel is processed per clock; `idx` increments each clock.
  - SCAN -> IDLE after processing `idx == CHANNELS-1`.
- `s` is latched into `snap` on `tick`, so every channel in one pass uses the same sample instant.
- Per-channel processing of channel `ch`:
  - If `snap[ch] == out[ch]`: `cnt[ch] <= 0`.
  - Else if `cnt[ch] == STABLE-1`: `out[ch] <= snap[ch]`, `cnt[ch] <= 0`, and an event is raised.
  - Else: `cnt[ch] <= cnt[ch] + 1`.
- `cnt` width is clog2(STABLE). It never exceeds STABLE-1, so it cannot wrap.
- `busy` equals (state == SCAN).
- A `tick` arriving during SCAN cannot occur, because PRESCALE > CHANNELS+1.
- Reset values: `out = 0`; all `cnt = 0`; synchronizer and `snap` = 0; `pcnt = 0`; state IDLE; `idx = 0`; `busy = 0`; `event_valid = 0`; `event_chan = 0`; `event_level = 0`; `event_ovf = 0`.
- Reset asserted mid-scan abandons the pass. All of the above values apply on the next clock.

## Timing
- Channel `ch` is updated on the clock edge `ch+1` cycles after the `tick` edge. `out[ch]` changes at that edge.
- A clean edge on `in` that is stable from before a tick produces an `out` change at the STABLE-th tick.
  - Worst-case latency: 2 (synchronizer) + STABLE·PRESCALE + CHANNELS clocks.
- Any single sample that agrees with `out[ch]` restarts that channel's count.
- `event_valid` asserts on the same edge as the `out` toggle.
- `event_valid`, `event_chan` and `event_level` hold until a cycle with `event_ack` high.
  - `event_ack` while `event_valid` is low is ignored.
- An event raised in the same cycle as `event_ack` with `event_valid` high:
  - The new event is loaded.
  - `event_valid` stays high.
  - No overflow.
- An event raised while `event_valid` is high and `event_ack` is low:
  - The new event is dropped.
  - The held event is unchanged.
  - `event_ovf <= 1`.
- At most one event is raised per clock, since only one channel is processed per clock.

## Configuration
- Macro: `DEBOUNCE_SCANNER_EVENT_EN`.
- Defined: the event register, `event_ack` handling and `event_ovf` are compiled in and behave as above.
- Undefined:
  - No event storage logic is built.
  - `event_valid`, `event_chan`, `event_level` and `event_ovf` are tied to 0.
  - `event_ack` is ignored.
  - `out`, `busy` and the scan behaviour are identical to the defined build.

## Test plan
All scenarios use CHANNELS=4, PRESCALE=16, STABLE=4.

- Reset, then hold `in = 4'b0000` for 200 clocks -> `out = 0`, `busy` pulses 4 clocks every 16, `event_valid` never rises.
- Set `in[2] = 1` cleanly just after a tick -> `out[2]` rises exactly 3 clocks after the 4th subsequent tick. `event_valid = 1`, `event_chan = 2`, `event_level = 1`. The other outputs are unchanged.
- Toggle `in[1]` so it is high for 3 ticks, low for 1 tick, then high for 4 ticks -> `out[1]` rises only at the end of the 4-tick run; no event is raised earlier.
- Raise `in[0]` and `in[3]` together, no `event_ack` -> a channel-0 event is held and `event_ovf = 1` after the channel-3 toggle. Repeat with `event_ack` pulsed in the cycle of the channel-3 update -> `event_chan = 3`, `event_ovf = 0`.
- Assert `reset` for 1 clock during SCAN with `out = 4'b1111` -> next clock all outputs are 0 and state is IDLE. The first post-reset pass starts 16 clocks later.
- Build without `DEBOUNCE_SCANNER_EVENT_EN` and repeat the second scenario -> `out[2]` timing is identical; all event outputs stay 0.

Source files
------------

// File: rtl/debounce_scanner_if.sv
// debounce_scanner_if: raw inputs, debounced levels, busy flag and change-event port
interface debounce_scanner_if #(
    parameter int CHANNELS = 4
);
    localparam int CW = $clog2(CHANNELS);
    logic [CHANNELS-1:0] in_i;
    logic [CHANNELS-1:0] out_o;
    logic                busy_o;
    logic                event_valid_o;
    logic [CW-1:0]       event_chan_o;
    logic                event_level_o;
    logic                event_ack_i;
    logic                event_ovf_o;
    modport master (
        input  in_i, event_ack_i,
        output out_o, busy_o, event_valid_o, event_chan_o, event_level_o, event_ovf_o
    );
    modport slave (
        output in_i, event_ack_i,
        input  out_o, busy_o, event_valid_o, event_chan_o, event_level_o, event_ovf_o
    );
endinterface

// File: rtl/debounce_scanner.sv
// debounce_scanner: time-shared debouncer; change-event port built only with DEBOUNCE_SCANNER_EVENT_EN
module debounce_scanner #(
    parameter int CHANNELS = 4,
    parameter int PRESCALE = 1024,
    parameter int STABLE   = 4
) (
    input logic                clk_i,
    input logic                rst_i,
    debounce_scanner_if.master bus
);
    localparam int CW = $clog2(CHANNELS);
    localparam int PW = $clog2(PRESCALE);
    localparam int SW = $clog2(STABLE);
    typedef enum logic {IDLE, SCAN} state_t;
    state_t              state_q, state_d;
    logic [CHANNELS-1:0] sync1_q, sync2_q, snap_q, out_q, out_d;
    logic [PW-1:0]       pcnt_q, pcnt_d;
    logic [CW-1:0]       idx_q, idx_d;
    logic [SW-1:0]       cnt_q [CHANNELS];
    logic [SW-1:0]       cnt_d;
    logic                tick, raise;

    assign tick       = pcnt_q == PW'(PRESCALE - 1);
    assign pcnt_d     = tick ? '0 : pcnt_q + 1'b1;
    assign bus.out_o  = out_q;
    assign bus.busy_o = state_q == SCAN;

    // synchronizer, prescaler, tick snapshot, scan FSM and debounced levels
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
            snap_q  <= '0;
            pcnt_q  <= '0;
            state_q <= IDLE;
            idx_q   <= '0;
            out_q   <= '0;
        end else begin
            sync1_q <= bus.in_i;
            sync2_q <= sync1_q;
            pcnt_q  <= pcnt_d;
            state_q <= state_d;
            idx_q   <= idx_d;
            out_q   <= out_d;
            if (tick) snap_q <= sync2_q;
        end
    end

    // stability counters; only the channel under scan is written each clock
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
        end else if (state_q == SCAN) begin
            cnt_q[idx_q] <= cnt_d;
        end
    end

    // next state, scan index and the shared per-channel stability datapath
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        out_d   = out_q;
        cnt_d   = cnt_q[idx_q];
        raise   = 1'b0;
        if (state_q == IDLE) begin
            if (tick) begin
                state_d = SCAN;
                idx_d   = '0;
            end
        end else begin
            state_d = idx_q == CW'(CHANNELS - 1) ? IDLE : SCAN;
            idx_d   = idx_q == CW'(CHANNELS - 1) ? '0 : idx_q + 1'b1;
            if (snap_q[idx_q] == out_q[idx_q]) begin
                cnt_d = '0;
            end else if (cnt_q[idx_q] == SW'(STABLE - 1)) begin
                out_d[idx_q] = snap_q[idx_q];
                cnt_d        = '0;
                raise        = 1'b1;
            end else begin
                cnt_d = cnt_q[idx_q] + 1'b1;
            end
        end
    end

`ifdef DEBOUNCE_SCANNER_EVENT_EN
    logic          ev_valid_q, ev_level_q, ev_ovf_q;
    logic [CW-1:0] ev_chan_q;

    assign bus.event_valid_o = ev_valid_q;
    assign bus.event_chan_o  = ev_chan_q;
    assign bus.event_level_o = ev_level_q;
    assign bus.event_ovf_o   = ev_ovf_q;

    // single-entry event holder; a raise coinciding with an ack replaces the popped entry
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ev_valid_q <= 1'b0;
            ev_chan_q  <= '0;
            ev_level_q <= 1'b0;
            ev_ovf_q   <= 1'b0;
        end else if (raise && (!ev_valid_q || bus.event_ack_i)) begin
            ev_valid_q <= 1'b1;
            ev_chan_q  <= idx_q;
            ev_level_q <= snap_q[idx_q];
        end else if (raise) begin
            ev_ovf_q <= 1'b1;
        end else if (bus.event_ack_i) begin
            ev_valid_q <= 1'b0;
        end
    end
`else
    logic unused_ev;
    assign unused_ev         = bus.event_ack_i | raise;
    assign bus.event_valid_o = 1'b0;
    assign bus.event_chan_o  = '0;
    assign bus.event_level_o = 1'b0;
    assign bus.event_ovf_o   = 1'b0;
`endif
endmodule

// File: tb/tb_debounce_scanner.sv
// tb_debounce_scanner: directed checks of scan timing, debounce counting, events and reset
module tb_debounce_scanner;
`ifdef DEBOUNCE_SCANNER_EVENT_EN
    localparam logic EV = 1'b1;
`else
    localparam logic EV = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    debounce_scanner_if #(.CHANNELS(4)) bus ();

    debounce_scanner #(.CHANNELS(4), .PRESCALE(16), .STABLE(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        bus.in_i        = '0;
        bus.event_ack_i = 1'b0;
        rst             = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_rise();
        logic prev;
        bit   seen;
        seen = 0;
        prev = bus.busy_o;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = !prev && bus.busy_o;
            prev = bus.busy_o;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL busy_rise: got no rise, expected a rise within 40 clocks");
        end
    endtask

    task automatic test_reset();
        bus.in_i        = '0;
        bus.event_ack_i = 1'b0;
        rst             = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({bus.out_o, bus.busy_o, bus.event_valid_o, bus.event_chan_o, bus.event_level_o, bus.event_ovf_o} !== 10'b0) begin
            errors++;
            $display("FAIL reset_outputs: got out=%b busy=%b ev=%b chan=%0d lvl=%b ovf=%b, expected all 0",
                     bus.out_o, bus.busy_o, bus.event_valid_o, bus.event_chan_o, bus.event_level_o, bus.event_ovf_o);
        end
    endtask

    task automatic test_idle();
        int  busy_cnt = 0;
        int  first = 0;
        bit  bad_out = 0;
        bit  bad_ev = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (bus.busy_o) begin
                busy_cnt++;
                if (first == 0) first = i;
            end
            if (bus.out_o !== 4'b0) bad_out = 1;
            if (bus.event_valid_o !== 1'b0) bad_ev = 1;
        end
        checks++;
        if (busy_cnt !== 48) begin
            errors++;
            $display("FAIL idle_busy_count: got %0d, expected 48", busy_cnt);
        end
        checks++;
        if (first !== 16) begin
            errors++;
            $display("FAIL idle_first_pass: got %0d, expected 16", first);
        end
        checks++;
        if (bad_out) begin
            errors++;
            $display("FAIL idle_out: got nonzero out, expected 0");
        end
        checks++;
        if (bad_ev) begin
            errors++;
            $display("FAIL idle_event: got event_valid high, expected low");
        end
    endtask

    task automatic test_single();
        do_reset();
        wait_rise();
        bus.in_i = 4'b0100;
        repeat (66) @(negedge clk);
        checks++;
        if (bus.out_o !== 4'b0000 || bus.event_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL single_early: got out=%b ev=%b, expected out=0000 ev=0", bus.out_o, bus.event_valid_o);
        end
        @(negedge clk);
        checks++;
        if (bus.out_o !== 4'b0100) begin
            errors++;
            $display("FAIL single_out: got %b, expected 0100", bus.out_o);
        end
        checks++;
        if (bus.event_valid_o !== EV || bus.event_chan_o !== (EV ? 2'd2 : 2'd0) || bus.event_level_o !== EV || bus.event_ovf_o !== 1'b0) begin
            errors++;
            $display("FAIL single_event: got ev=%b chan=%0d lvl=%b ovf=%b, expected ev=%b chan=%0d lvl=%b ovf=0",
                     bus.event_valid_o, bus.event_chan_o, bus.event_level_o, bus.event_ovf_o, EV, EV ? 2 : 0, EV);
        end
        bus.event_ack_i = 1'b1;
        @(negedge clk);
        bus.event_ack_i = 1'b0;
        checks++;
        if (bus.event_valid_o !== 1'b0 || bus.out_o !== 4'b0100) begin
            errors++;
            $display("FAIL single_ack: got ev=%b out=%b, expected ev=0 out=0100", bus.event_valid_o, bus.out_o);
        end
    endtask

    task automatic test_bounce();
        do_reset();
        wait_rise();
        bus.in_i = 4'b0010;
        repeat (3) wait_rise();
        bus.in_i = 4'b0000;
        wait_rise();
        bus.in_i = 4'b0010;
        repeat (3) wait_rise();
        repeat (3) @(negedge clk);
        checks++;
        if (bus.out_o !== 4'b0000 || bus.event_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL bounce_early: got out=%b ev=%b, expected out=0000 ev=0", bus.out_o, bus.event_valid_o);
        end
        wait_rise();
        @(negedge clk);
        checks++;
        if (bus.out_o !== 4'b0000) begin
            errors++;
            $display("FAIL bounce_pre_edge: got %b, expected 0000", bus.out_o);
        end
        @(negedge clk);
        checks++;
        if (bus.out_o !== 4'b0010 || bus.event_valid_o !== EV || bus.event_chan_o !== (EV ? 2'd1 : 2'd0)) begin
            errors++;
            $display("FAIL bounce_rise: got out=%b ev=%b chan=%0d, expected out=0010 ev=%b chan=%0d",
                     bus.out_o, bus.event_valid_o, bus.event_chan_o, EV, EV ? 1 : 0);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        wait_rise();
        bus.in_i = 4'b1001;
        repeat (4) wait_rise();
        @(negedge clk);
        checks++;
        if (bus.out_o !== 4'b0001 || bus.event_valid_o !== EV || bus.event_chan_o !== 2'd0 || bus.event_ovf_o !== 1'b0) begin
            errors++;
            $display("FAIL ovf_first: got out=%b ev=%b chan=%0d ovf=%b, expected out=0001 ev=%b chan=0 ovf=0",
                     bus.out_o, bus.event_valid_o, bus.event_chan_o, bus.event_ovf_o, EV);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.out_o !== 4'b1001 || bus.event_chan_o !== 2'd0 || bus.event_level_o !== EV || bus.event_ovf_o !== EV) begin
            errors++;
            $display("FAIL ovf_drop: got out=%b chan=%0d lvl=%b ovf=%b, expected out=1001 chan=0 lvl=%b ovf=%b",
                     bus.out_o, bus.event_chan_o, bus.event_level_o, bus.event_ovf_o, EV, EV);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        wait_rise();
        bus.in_i = 4'b1001;
        repeat (4) wait_rise();
        repeat (3) @(negedge clk);
        bus.event_ack_i = 1'b1;
        @(negedge clk);
        bus.event_ack_i = 1'b0;
        checks++;
        if (bus.out_o !== 4'b1001 || bus.event_valid_o !== EV || bus.event_chan_o !== (EV ? 2'd3 : 2'd0) || bus.event_ovf_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_replace: got out=%b ev=%b chan=%0d ovf=%b, expected out=1001 ev=%b chan=%0d ovf=0",
                     bus.out_o, bus.event_valid_o, bus.event_chan_o, bus.event_ovf_o, EV, EV ? 3 : 0);
        end
    endtask

    task automatic test_reset_mid_scan();
        int first = 0;
        do_reset();
        wait_rise();
        bus.in_i = 4'b1111;
        repeat (4) wait_rise();
        repeat (4) @(negedge clk);
        checks++;
        if (bus.out_o !== 4'b1111 || bus.event_ovf_o !== EV) begin
            errors++;
            $display("FAIL mid_setup: got out=%b ovf=%b, expected out=1111 ovf=%b", bus.out_o, bus.event_ovf_o, EV);
        end
        wait_rise();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({bus.out_o, bus.busy_o, bus.event_valid_o, bus.event_chan_o, bus.event_level_o, bus.event_ovf_o} !== 10'b0) begin
            errors++;
            $display("FAIL mid_reset: got out=%b busy=%b ev=%b chan=%0d lvl=%b ovf=%b, expected all 0",
                     bus.out_o, bus.busy_o, bus.event_valid_o, bus.event_chan_o, bus.event_level_o, bus.event_ovf_o);
        end
        for (int i = 1; i <= 40 && first == 0; i++) begin
            @(negedge clk);
            if (bus.busy_o) first = i;
        end
        checks++;
        if (first !== 16) begin
            errors++;
            $display("FAIL mid_restart: got first pass after %0d clocks, expected 16", first);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single();
        test_bounce();
        test_overflow();
        test_back_to_back();
        test_reset_mid_scan();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
